demux_1to16_ab_match_result: RTL
================================

// Module: demux_1to16_ab_match_result
// PURPOSE
//  Scatters a stream of 128-bit match-result words, each tagged with a lane number, into 16 lanes.
//  Each lane holds one word in its own buffer and offers it on a valid/ready port.
//  A word is written as 32-bit fields under per-field enables.
//  It becomes visible on its lane when the write that carries in_last is accepted.
//  Sits between the central match-result bus and the per-lane back-end consumers.
//  Inverse of the 16:1 match-result selector.
// PARAMETERS
//  FIELD_W   32  width of one field
//  NFIELD    4   fields per word; DATA_W = FIELD_W*NFIELD = 128
//  LANES     16  number of output lanes (2..16)
//  SEL_W     4   width of in_sel
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous reset, active-high
//  in_valid     in   1          input word/fields valid
//  in_ready     out  1          input accepted this cycle when in_valid&in_ready
//  in_sel       in   SEL_W      destination lane
//  in_field_en  in   NFIELD     write enable per field; bit k covers data[32k+31:32k]
//  in_last      in   1          this write completes the lane's word
//  in_data      in   DATA_W     field data
//  out_valid    out  LANES      lane i holds a complete word
//  out_ready    in   LANES      lane i consumer takes word
//  out_data     out  LANES*DATA_W  lane i word at [i*128+127:i*128]
//  err_sel      out  1          one-cycle pulse: accepted write had in_sel >= LANES
//  word_cnt     out  16         count of words completed (in_last accepted), wraps
// BEHAVIOUR
//  Reset (async, any time): out_valid=0, all staging/out_data=0, err_sel=0, word_cnt=0.
//   Partial words are discarded.
//  Each lane has two states:
//   FILL: out_valid=0, fields may accumulate.
//   FULL: out_valid=1, contents frozen.
//  in_ready is combinational, with L = in_sel:
//   if L >= LANES: in_ready = 1 (the write is sunk).
//   else in_ready = !out_valid[L] | out_ready[L] (a lane may drain and refill in the same cycle).
//  On accept to lane L, for each k with in_field_en[k]=1: stage[L].field[k] <= in_data field k.
//   Other fields keep their value.
//   If in_last=1: lane L -> FULL next cycle, and word_cnt increments.
//  Latency: accept with in_last at cycle t -> out_valid[L]=1 at t+1, with out_data holding the merged word.
//  Drain: out_valid[i]&out_ready[i] -> lane i returns to FILL and its staging is cleared to 0 next cycle.
//  Drain and write to the same lane in the same cycle: clear first, then apply the enabled fields.
//   If that write has in_last=1, the lane stays FULL with only the new fields; the other fields read 0.
//  in_field_en=0 with in_last=1 is legal: the lane completes with its current contents.
//  in_sel >= LANES and accepted: no state change, word_cnt unchanged, err_sel=1 at t+1 for one cycle.
//  Independent lanes drain concurrently; a FULL lane never blocks writes to other lanes.
//  out_data of a FILL lane is undefined to consumers (it shows the staging value).
//  word_cnt is 16-bit unsigned and wraps 0xFFFF -> 0x0000.
// TESTING
//  1. Reset, then write sel=5, en=4'hF, last=1, data=128'h0123..CDEF.
//     -> out_valid=16'h0020 next cycle; lane5 data matches; word_cnt=1.
//  2. Three writes to sel=3 (en=1, en=2, then en=C with last=1), fields A,B,C,D.
//     -> lane3 = {D,C,B,A} only after the third write; out_valid[3] stays 0 until then.
//  3. Lane 7 FULL with out_ready[7]=0, then write sel=7.
//     -> in_ready=0 and the data is held. Raise out_ready[7] together with a write of en=1, last=1, field=X.
//     -> lane7 = {0,0,0,X} and stays valid.
//  4. LANES=12: write sel=13.
//     -> in_ready=1, err_sel pulses once, no out_valid change, word_cnt unchanged.
//  5. Assert rst mid-fill on lane 2 (en=1 written, no last), then complete with en=2, last=1, field=Y.
//     -> lane2 = {0,0,Y,0}.
//  6. Random traffic over all 16 lanes with random out_ready for 10k cycles, checked against a scoreboard.
//     -> no loss, no duplication, word_cnt matches the scoreboard mod 2^16.

Source files
------------

// File: rtl/demux_1to16_ab_match_result.sv
// Scatters tagged 128-bit match-result words into per-lane single-word buffers.
// Each word is assembled field by field and published on its lane when the in_last write is taken.
module demux_1to16_ab_match_result #(
    parameter int FIELD_W = 32,
    parameter int NFIELD  = 4,
    parameter int LANES   = 16,
    parameter int SEL_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic [NFIELD-1:0]           in_field_en,
    input  logic                        in_last,
    input  logic [FIELD_W*NFIELD-1:0]   in_data,
    output logic [LANES-1:0]            out_valid,
    input  logic [LANES-1:0]            out_ready,
    output logic [LANES*FIELD_W*NFIELD-1:0] out_data,
    output logic                        err_sel,
    output logic [15:0]                 word_cnt
);

    localparam int DATA_W   = FIELD_W * NFIELD;
    localparam int SEL_SPAN = 1 << SEL_W;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } lane_state_t;

    logic                  sel_ok;
    logic                  accept;
    logic                  accept_ok;
    logic [SEL_SPAN-1:0]   lane_free;
    logic [DATA_W-1:0]     field_mask;
    logic [LANES-1:0]      lane_wr;
    logic [LANES-1:0]      lane_drain;
    logic                  err_sel_reg;
    logic [15:0]           word_cnt_reg;

    assign sel_ok    = ({{(32-SEL_W){1'b0}}, in_sel} < 32'(LANES));
    assign in_ready  = lane_free[in_sel];
    assign accept    = in_valid & in_ready;
    assign accept_ok = accept & sel_ok;

    // Selector codes with no lane behind them always look free so the write is sunk.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_free
            if (gi < LANES) begin : g_lane
                assign lane_free[gi] = ~out_valid[gi] | out_ready[gi];
            end else begin : g_sink
                assign lane_free[gi] = 1'b1;
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NFIELD; gi++) begin : g_mask
            assign field_mask[gi*FIELD_W +: FIELD_W] = {FIELD_W{in_field_en[gi]}};
        end
    endgenerate

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_state_t       state_reg;
            logic [DATA_W-1:0] stage_reg;
            logic [DATA_W-1:0] base;
            logic [DATA_W-1:0] stage_next;

            assign lane_wr[gi]    = accept_ok & (in_sel == SEL_W'(gi));
            assign lane_drain[gi] = (state_reg == FULL) & out_ready[gi];

            // A drain clears the buffer before a same-cycle write merges its fields in.
            assign base       = lane_drain[gi] ? '0 : stage_reg;
            assign stage_next = (base & ~field_mask) | (in_data & field_mask);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= FILL;
                    stage_reg <= '0;
                end else if (lane_wr[gi]) begin
                    stage_reg <= stage_next;
                    if (in_last) begin
                        state_reg <= FULL;
                    end else if (lane_drain[gi]) begin
                        state_reg <= FILL;
                    end
                end else if (lane_drain[gi]) begin
                    stage_reg <= '0;
                    state_reg <= FILL;
                end
            end

            assign out_valid[gi]                  = (state_reg == FULL);
            assign out_data[gi*DATA_W +: DATA_W]  = stage_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_reg  <= 1'b0;
            word_cnt_reg <= '0;
        end else begin
            err_sel_reg  <= accept & ~sel_ok;
            word_cnt_reg <= word_cnt_reg + 16'(accept_ok & in_last);
        end
    end

    assign err_sel  = err_sel_reg;
    assign word_cnt = word_cnt_reg;

endmodule
